// File: rtl/pipe_mem_pkg.sv
// Shared constants, region type and byte-merge helper for the MEM stage.
// I/O word offsets live in addr[6:2] when the I/O select bit is set.
package pipe_mem_pkg;

  localparam logic [4:0] OFS_IN_BASE = 5'h10;
  localparam logic [4:0] OFS_MASK    = 5'h1E;
  localparam logic [4:0] OFS_FLAGS   = 5'h1F;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_OUT,
    RGN_IN,
    RGN_MASK,
    RGN_FLAGS
  } region_e;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_d,
    input logic [31:0] new_d,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_d;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/pipe_mem_io_in_sync.sv
// One input channel: SYNC_STAGES-deep synchroniser, previous-value
// register and change pulse. Ports: clock, reset, din -> sync, change.
module io_in_sync #(
  parameter int STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] din,
  output logic [31:0] sync,
  output logic        change
);

  logic [31:0] stg [STAGES];
  logic [31:0] prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++)
        stg[i] <= '0;
      prev <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < STAGES; i++)
        stg[i] <= stg[i-1];
      prev <= stg[STAGES-1];
    end
  end

  assign sync   = stg[STAGES-1];
  assign change = (sync != prev);

endmodule

// File: rtl/pipe_mem_io.sv
// MEM-stage data RAM plus memory-mapped I/O (out regs, synced inputs,
// sticky change flags). Ports: clock, reset, we, re, be, addr, datain,
// dataout, dout_valid, out_port, in_port; irq if IO_CHANGE_IRQ_EN.
module pipe_mem_io
  import pipe_mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 5,
  parameter int NUM_OUT     = 3,
  parameter int NUM_IN      = 2,
  parameter int IO_BIT      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [3:0]            be,
  input  logic [31:0]           addr,
  input  logic [31:0]           datain,
  output logic [31:0]           dataout,
  output logic                  dout_valid,
  output logic [NUM_OUT*32-1:0] out_port,
  input  logic [NUM_IN*32-1:0]  in_port
`ifdef IO_CHANGE_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int         WORDS   = 1 << DEPTH_LOG2;
  localparam logic [4:0] OUT_LIM = 5'(NUM_OUT);
  localparam logic [4:0] IN_LIM  = OFS_IN_BASE + 5'(NUM_IN);

  logic [31:0]           ram [WORDS];
  logic [31:0]           out_q [NUM_OUT];
  logic [31:0]           in_sync [NUM_IN];
  logic [NUM_IN-1:0]     change;
  logic [NUM_IN-1:0]     flags;
  logic                  is_io;
  logic [4:0]            ofs;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  flag_clr;
  logic [31:0]           rd_data;
  region_e               rgn;

  // Address bits outside the decoded fields are don't-care (RAM aliases).
  logic                  unused_addr;
  assign unused_addr = ^addr;

  assign is_io = addr[IO_BIT];
  assign ofs   = addr[6:2];
  assign widx  = addr[2 +: DEPTH_LOG2];

  always_comb begin
    rgn = RGN_NONE;
    unique case (1'b1)
      !is_io:
        rgn = RGN_RAM;
      is_io && (ofs < OUT_LIM):
        rgn = RGN_OUT;
      is_io && (ofs >= OFS_IN_BASE) && (ofs < IN_LIM):
        rgn = RGN_IN;
`ifdef IO_CHANGE_IRQ_EN
      is_io && (ofs == OFS_MASK):
        rgn = RGN_MASK;
`endif
      is_io && (ofs == OFS_FLAGS):
        rgn = RGN_FLAGS;
      default:
        rgn = RGN_NONE;
    endcase
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    io_in_sync #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clock  (clock),
      .reset  (reset),
      .din    (in_port[32*g +: 32]),
      .sync   (in_sync[g]),
      .change (change[g])
    );
  end

`ifdef IO_CHANGE_IRQ_EN
  logic [NUM_IN-1:0] mask;
  logic [31:0]       mask_wr;

  assign mask_wr = byte_merge(32'(mask), datain, be);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (we && rgn == RGN_MASK)
        mask <= mask_wr[NUM_IN-1:0];
      irq <= |(flags & mask);
    end
  end
`endif

  // Read mux sees pre-edge state, so same-edge we&re is read-first.
  always_comb begin
    rd_data = '0;
    case (rgn)
      RGN_RAM:
        rd_data = ram[widx];
      RGN_OUT:
        for (int k = 0; k < NUM_OUT; k++)
          if (ofs == 5'(k)) rd_data = out_q[k];
      RGN_IN:
        for (int k = 0; k < NUM_IN; k++)
          if (ofs == OFS_IN_BASE + 5'(k)) rd_data = in_sync[k];
`ifdef IO_CHANGE_IRQ_EN
      RGN_MASK:
        rd_data = 32'(mask);
`endif
      RGN_FLAGS:
        rd_data = 32'(flags);
      default:
        rd_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (we && rgn == RGN_RAM)
      ram[widx] <= byte_merge(ram[widx], datain, be);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++)
        out_q[k] <= '0;
    end else if (we && rgn == RGN_OUT) begin
      for (int k = 0; k < NUM_OUT; k++)
        if (ofs == 5'(k))
          out_q[k] <= byte_merge(out_q[k], datain, be);
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_port[32*g +: 32] = out_q[g];
  end

  // Clear applies first so a change on the clearing edge survives.
  assign flag_clr = re && (rgn == RGN_FLAGS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      flags <= '0;
    else
      flags <= (flags & ~{NUM_IN{flag_clr}}) | change;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dataout    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= re;
      if (re)
        dataout <= rd_data;
    end
  end

endmodule
